// File: rtl/matmul_seq_ctrl_if.sv
// rtl/matmul_seq_ctrl_if.sv - host command, operand memory and PCPI signal bundle
interface matmul_seq_ctrl_if #(
   parameter int MEM_AW = 8
);
   // host job command
   logic              cmd_valid;
   logic              cmd_ready;
   logic [MEM_AW-1:0] cmd_base;
   logic [3:0]        cmd_mask;

   // operand memory read port
   logic              mem_rd_en;
   logic [MEM_AW-1:0] mem_addr;
   logic [15:0]       mem_rdata;

   // coprocessor instruction port
   logic              pcpi_valid;
   logic [31:0]       pcpi_insn;
   logic              pcpi_ready;
   logic              pcpi_wait;

   // job status
   logic              done;
   logic              err;

   // controller side
   modport master (
      input  cmd_valid, cmd_base, cmd_mask, mem_rdata, pcpi_ready, pcpi_wait,
      output cmd_ready, mem_rd_en, mem_addr, pcpi_valid, pcpi_insn, done, err
   );

   // host / memory / coprocessor side
   modport slave (
      output cmd_valid, cmd_base, cmd_mask, mem_rdata, pcpi_ready, pcpi_wait,
      input  cmd_ready, mem_rd_en, mem_addr, pcpi_valid, pcpi_insn, done, err
   );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - operand load and start/run/clear sequencer for a PCPI matmul coprocessor
module matmul_seq_ctrl #(
   parameter int MEM_AW  = 8,
   parameter int TIMEOUT = 64
) (
   input logic              clk,
   input logic              rst,
   matmul_seq_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      RUN,
      CLEAR,
      DONE
   } state_t;

   localparam logic [6:0] OPCODE   = 7'b0001011;
   localparam logic [2:0] F3_WRITE = 3'b000;
   localparam logic [2:0] F3_START = 3'b111;
   localparam logic [2:0] F3_CLEAR = 3'b101;
   localparam logic [7:0] RUN_LAST = 8'(TIMEOUT - 1);

   // Operand groups: A 0..8, B 9..17, bias 18..26, threshold 27.
   function automatic logic [1:0] group_of(input int a);
      if (a < 9)       return 2'd0;
      else if (a < 18) return 2'd1;
      else if (a < 27) return 2'd2;
      else             return 2'd3;
   endfunction

   // Lowest enabled operand address at or above 'from'; bit 5 flags a hit.
   function automatic logic [5:0] next_enabled(input logic [4:0] from, input logic [3:0] mask);
      logic [5:0] res;
      res = '0;
      for (int a = 27; a >= 0; a--) begin
         if ((5'(a) >= from) && mask[group_of(a)]) begin
            res = {1'b1, 5'(a)};
         end
      end
      return res;
   endfunction

   function automatic logic [31:0] make_insn(input logic [2:0] f3, input logic [4:0] addr,
                                             input logic [15:0] value);
      return {1'b0, value, f3, addr, OPCODE};
   endfunction

   state_t            state;
   logic [MEM_AW-1:0] base_q;
   logic [3:0]        mask_q;
   logic [4:0]        k;
   logic [7:0]        run_cnt;
   // LOAD/START: 0 on the first cycle (capture / valid gap), 1 while the insn is offered
   logic              phase;

   logic              cmd_ready_q;
   logic              mem_rd_en_q;
   logic [MEM_AW-1:0] mem_addr_q;
   logic              pcpi_valid_q;
   logic [31:0]       pcpi_insn_q;
   logic              done_q;
   logic              err_q;

   logic [5:0]        first_en;
   logic [5:0]        next_en;

   // Address search for job start (from the live command) and for advancing k.
   always_comb begin
      first_en = next_enabled(5'd0, bus.cmd_mask);
      next_en  = next_enabled(k + 5'd1, mask_q);
   end

   // Sequencer: one state register, all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         base_q       <= '0;
         mask_q       <= '0;
         k            <= '0;
         run_cnt      <= '0;
         phase        <= 1'b0;
         cmd_ready_q  <= 1'b1;
         mem_rd_en_q  <= 1'b0;
         mem_addr_q   <= '0;
         pcpi_valid_q <= 1'b0;
         pcpi_insn_q  <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid && cmd_ready_q) begin
                  base_q      <= bus.cmd_base;
                  mask_q      <= bus.cmd_mask;
                  err_q       <= 1'b0;
                  cmd_ready_q <= 1'b0;
                  phase       <= 1'b0;
                  if (first_en[5]) begin
                     k           <= first_en[4:0];
                     mem_rd_en_q <= 1'b1;
                     mem_addr_q  <= bus.cmd_base + MEM_AW'(first_en[4:0]);
                     state       <= FETCH;
                  end else begin
                     k     <= '0;
                     state <= START;
                  end
               end
            end

            FETCH: begin
               mem_rd_en_q <= 1'b0;
               phase       <= 1'b0;
               state       <= LOAD;
            end

            LOAD: begin
               if (!phase) begin
                  // memory data is valid in this first LOAD cycle
                  phase        <= 1'b1;
                  pcpi_valid_q <= 1'b1;
                  pcpi_insn_q  <= make_insn(F3_WRITE, k, bus.mem_rdata);
               end else if (bus.pcpi_ready) begin
                  pcpi_valid_q <= 1'b0;
                  pcpi_insn_q  <= '0;
                  phase        <= 1'b0;
                  if (next_en[5]) begin
                     k           <= next_en[4:0];
                     mem_rd_en_q <= 1'b1;
                     mem_addr_q  <= base_q + MEM_AW'(next_en[4:0]);
                     state       <= FETCH;
                  end else begin
                     state <= START;
                  end
               end
            end

            START: begin
               // first cycle keeps valid low so a preceding write is separated
               if (!phase) begin
                  phase        <= 1'b1;
                  pcpi_valid_q <= 1'b1;
                  pcpi_insn_q  <= make_insn(F3_START, 5'd0, 16'd0);
               end else if (bus.pcpi_ready) begin
                  phase        <= 1'b0;
                  pcpi_valid_q <= 1'b0;
                  pcpi_insn_q  <= '0;
                  run_cnt      <= '0;
                  state        <= RUN;
               end
            end

            RUN: begin
               run_cnt <= run_cnt + 8'd1;
               // the first RUN cycle may still show the START handshake, so it is ignored
               if ((run_cnt != 8'd0) && bus.pcpi_ready && !bus.pcpi_wait) begin
                  pcpi_valid_q <= 1'b1;
                  pcpi_insn_q  <= make_insn(F3_CLEAR, 5'd0, 16'd0);
                  state        <= CLEAR;
               end else if (run_cnt == RUN_LAST) begin
                  err_q        <= 1'b1;
                  pcpi_valid_q <= 1'b1;
                  pcpi_insn_q  <= make_insn(F3_CLEAR, 5'd0, 16'd0);
                  state        <= CLEAR;
               end
            end

            CLEAR: begin
               if (bus.pcpi_ready) begin
                  pcpi_valid_q <= 1'b0;
                  pcpi_insn_q  <= '0;
                  done_q       <= 1'b1;
                  state        <= DONE;
               end
            end

            DONE: begin
               done_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
               state       <= IDLE;
            end

            default: begin
               state       <= IDLE;
               cmd_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.cmd_ready  = cmd_ready_q;
   assign bus.mem_rd_en  = mem_rd_en_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.pcpi_valid = pcpi_valid_q;
   assign bus.pcpi_insn  = pcpi_insn_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb/tb_matmul_seq_ctrl.sv - scoreboard bench for matmul_seq_ctrl
module tb_matmul_seq_ctrl;

   localparam int MEM_AW  = 8;
   localparam int TIMEOUT = 16;

   localparam int MODE_NORMAL = 0;
   localparam int MODE_STALL4 = 1;
   localparam int MODE_BUSY8  = 2;
   localparam int MODE_HANG   = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   matmul_seq_ctrl_if #(.MEM_AW(MEM_AW)) bus ();

   matmul_seq_ctrl #(.MEM_AW(MEM_AW), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_insn_q[$];
   logic [7:0]  exp_addr_q[$];
   logic [15:0] mem[256];

   int          mode = MODE_NORMAL;
   logic [7:0]  cur_base = 8'h00;

   // monitor state
   int   cyc = 0;
   int   t111 = 0;
   int   t101 = 0;
   bit   prev_clr = 1'b0;
   bit   clr_now;
   int   done_cnt = 0;
   int   extra_cnt = 0;
   int   overlap_cnt = 0;
   int   stall_cnt = 0;

   // memory model state
   logic       rd_seen;
   logic [7:0] rd_addr;

   // coprocessor model state
   int   busy_left = 0;
   int   stall_left = 0;
   bit   hang = 1'b0;
   logic nr, nw, xfer;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk_insn(input logic [2:0] f3, input logic [4:0] a,
                                           input logic [15:0] v);
      return {1'b0, v, f3, a, 7'b0001011};
   endfunction

   function automatic int grp(input int a);
      if (a <= 8)       return 0;
      else if (a <= 17) return 1;
      else if (a <= 26) return 2;
      else              return 3;
   endfunction

   task automatic push_job(input logic [7:0] base, input logic [3:0] mask);
      for (int a = 0; a < 28; a++) begin
         if (mask[grp(a)]) begin
            exp_addr_q.push_back(8'(base + 8'(a)));
            exp_insn_q.push_back(mk_insn(3'b000, 5'(a), mem[8'(base + 8'(a))]));
         end
      end
      exp_insn_q.push_back(mk_insn(3'b111, 5'd0, 16'd0));
      exp_insn_q.push_back(mk_insn(3'b101, 5'd0, 16'd0));
   endtask

   task automatic start_job(input logic [7:0] base, input logic [3:0] mask, input bit hold);
      int n;
      n = 0;
      while (!bus.cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("cmd_ready_wait", bus.cmd_ready, 1);
      bus.cmd_base  = base;
      bus.cmd_mask  = mask;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      check_eq("accept_ready_low", bus.cmd_ready, 0);
      check_eq("err_cleared", bus.err, 0);
      if (hold) begin
         bus.cmd_base = 8'h00;
         bus.cmd_mask = 4'hF;
      end else begin
         bus.cmd_valid = 1'b0;
      end
   endtask

   task automatic run_job(input logic [7:0] base, input logic [3:0] mask, input int md,
                          input logic exp_err, input int exp_gap, input bit hold);
      int n, d0, x0, o0, s0;
      bit got;
      mode     = md;
      cur_base = base;
      push_job(base, mask);
      d0 = done_cnt;
      x0 = extra_cnt;
      o0 = overlap_cnt;
      s0 = stall_cnt;
      start_job(base, mask, hold);
      got = 1'b0;
      n   = 0;
      while (!got && n < 400) begin
         if (bus.done) got = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      bus.cmd_valid = 1'b0;
      check_eq("done_seen", got, 1);
      check_eq("err_at_done", bus.err, exp_err);
      check_eq("clear_gap", t101 - t111, exp_gap);
      @(negedge clk);
      check_eq("done_pulse_low", bus.done, 0);
      check_eq("idle_ready", bus.cmd_ready, 1);
      repeat (2) @(negedge clk);
      check_eq("done_count", done_cnt - d0, 1);
      check_eq("insn_left", exp_insn_q.size(), 0);
      check_eq("addr_left", exp_addr_q.size(), 0);
      check_eq("extra_strobes", extra_cnt - x0, 0);
      check_eq("rd_valid_overlap", overlap_cnt - o0, 0);
      check_eq("stall_cycles", stall_cnt - s0, (md == MODE_STALL4) ? 5 : 0);
      check_eq("err_sticky", bus.err, exp_err);
      exp_insn_q.delete();
      exp_addr_q.delete();
   endtask

   // Operand memory: data one cycle after the read strobe, junk otherwise.
   initial begin
      bus.mem_rdata = 16'hDEAD;
      forever begin
         @(negedge clk);
         rd_seen = bus.mem_rd_en;
         rd_addr = bus.mem_addr;
         @(posedge clk);
         #1;
         bus.mem_rdata = rd_seen ? mem[rd_addr] : 16'hDEAD;
      end
   end

   // Coprocessor model: decides next-cycle ready/wait from what it saw this cycle.
   initial begin
      bus.pcpi_ready = 1'b1;
      bus.pcpi_wait  = 1'b0;
      forever begin
         @(negedge clk);
         xfer = bus.pcpi_valid && bus.pcpi_ready;
         nr = 1'b1;
         nw = 1'b0;
         if (rst) begin
            busy_left  = 0;
            stall_left = 0;
            hang       = 1'b0;
         end else begin
            case (mode)
               MODE_STALL4: begin
                  if (bus.mem_rd_en && bus.mem_addr == 8'(cur_base + 8'd4)) stall_left = 6;
                  if (stall_left > 0) begin
                     nr = 1'b0;
                     stall_left--;
                  end
               end
               MODE_BUSY8: begin
                  if (xfer && bus.pcpi_insn[14:12] == 3'b111) busy_left = 8;
                  if (busy_left > 0) begin
                     nr = 1'b0;
                     nw = 1'b1;
                     busy_left--;
                  end
               end
               MODE_HANG: begin
                  if (xfer && bus.pcpi_insn[14:12] == 3'b111) hang = 1'b1;
                  if (bus.pcpi_valid && bus.pcpi_insn[14:12] == 3'b101) hang = 1'b0;
                  if (hang) begin
                     nr = 1'b0;
                     nw = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         @(posedge clk);
         #1;
         bus.pcpi_ready = nr;
         bus.pcpi_wait  = nw;
      end
   end

   // Monitor: pops the scoreboard on every memory read and PCPI transfer.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            if (bus.mem_rd_en) begin
               if (bus.pcpi_valid) overlap_cnt++;
               if (exp_addr_q.size() == 0) extra_cnt++;
               else check_eq("mem_addr", bus.mem_addr, exp_addr_q.pop_front());
            end
            if (bus.pcpi_valid && !bus.pcpi_ready && bus.pcpi_insn[14:12] == 3'b000 &&
                bus.pcpi_insn[11:7] == 5'd4) begin
               stall_cnt++;
               if (exp_insn_q.size() > 0) check_eq("stall_hold", bus.pcpi_insn, exp_insn_q[0]);
            end
            if (bus.pcpi_valid && bus.pcpi_ready) begin
               if (exp_insn_q.size() == 0) extra_cnt++;
               else check_eq("pcpi_insn", bus.pcpi_insn, exp_insn_q.pop_front());
               if (bus.pcpi_insn[14:12] == 3'b111) t111 = cyc;
            end
            clr_now = bus.pcpi_valid && bus.pcpi_insn[14:12] == 3'b101;
            if (clr_now && !prev_clr) t101 = cyc;
            prev_clr = clr_now;
            if (bus.done) done_cnt++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int x0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'((i - 16) & 255);
      bus.cmd_valid = 1'b0;
      bus.cmd_base  = '0;
      bus.cmd_mask  = '0;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_cmd_ready", bus.cmd_ready, 1);
      check_eq("rst_pcpi_valid", bus.pcpi_valid, 0);
      check_eq("rst_pcpi_insn", bus.pcpi_insn, 0);
      check_eq("rst_mem_rd_en", bus.mem_rd_en, 0);
      check_eq("rst_mem_addr", bus.mem_addr, 0);
      check_eq("rst_done", bus.done, 0);
      check_eq("rst_err", bus.err, 0);
      rst = 1'b0;

      // full load, cmd_valid held during the job
      run_job(8'h10, 4'hF, MODE_NORMAL, 1'b0, 3, 1'b1);
      // bias only, wrapped reads
      run_job(8'hFE, 4'h4, MODE_NORMAL, 1'b0, 3, 1'b0);
      // write of addr 4 held off five cycles
      run_job(8'h10, 4'h1, MODE_STALL4, 1'b0, 3, 1'b0);
      // coprocessor busy 8 cycles in RUN
      run_job(8'h20, 4'hA, MODE_BUSY8, 1'b0, 10, 1'b0);
      // coprocessor never completes: timeout after 16 RUN cycles
      run_job(8'h30, 4'h0, MODE_HANG, 1'b1, 17, 1'b0);
      repeat (4) @(negedge clk);
      check_eq("err_held_idle", bus.err, 1);

      // reset during LOAD of addr 12
      mode     = MODE_NORMAL;
      cur_base = 8'h10;
      push_job(8'h10, 4'hF);
      start_job(8'h10, 4'hF, 1'b0);
      n = 0;
      while (!(bus.pcpi_valid && bus.pcpi_insn[14:12] == 3'b000 && bus.pcpi_insn[11:7] == 5'd12)
             && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("reach_addr12", bus.pcpi_insn[11:7], 12);
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_mid_valid", bus.pcpi_valid, 0);
      check_eq("rst_mid_rd_en", bus.mem_rd_en, 0);
      check_eq("rst_mid_ready", bus.cmd_ready, 1);
      rst = 1'b0;
      exp_insn_q.delete();
      exp_addr_q.delete();
      x0 = extra_cnt;
      @(negedge clk);
      check_eq("post_rst_ready", bus.cmd_ready, 1);
      repeat (5) @(negedge clk);
      check_eq("post_rst_quiet", extra_cnt - x0, 0);

      run_job(8'h40, 4'h1, MODE_NORMAL, 1'b0, 3, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/matmul_seq_ctrl.md
MATMUL_SEQ_CTRL -- requirements
Module: matmul_seq_ctrl

Interface
REQ-001 Parameter MEM_AW, default 8, SHALL set the operand memory address width.
REQ-002 Parameter TIMEOUT, default 64, SHALL set the maximum RUN-state cycles before abort (range 2..255).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  host requests a job.
REQ-006 cmd_ready  output  1  high only in IDLE; a job is accepted when cmd_valid & cmd_ready.
REQ-007 cmd_base  input  MEM_AW  memory address of operand word 0.
REQ-008 cmd_mask  input  4  load enables: bit0 A (addr 0-8), bit1 B (9-17), bit2 bias (18-26), bit3 threshold (27).
REQ-009 mem_rd_en  output  1  operand read strobe.
REQ-010 mem_addr  output  MEM_AW  read address.
REQ-011 mem_rdata  input  16  read data, valid exactly one cycle after mem_rd_en.
REQ-012 pcpi_valid  output  1  coprocessor instruction valid.
REQ-013 pcpi_insn  output  32  coprocessor instruction.
REQ-014 pcpi_ready  input  1  coprocessor accept / completion.
REQ-015 pcpi_wait  input  1  coprocessor busy.
REQ-016 done  output  1  one-cycle pulse at job end.
REQ-017 err  output  1  sticky timeout flag of the last job; cleared on next job accept.

Function
REQ-018 pcpi_insn SHALL be {1'b0, value[15:0], funct3[2:0], addr[4:0], 7'b0001011}; bits not used by an instruction SHALL be zero.
REQ-019 States SHALL be IDLE, FETCH, LOAD, START, RUN, CLEAR, DONE.
REQ-020 On accept, controller SHALL latch cmd_base and cmd_mask, clear err, set index k to the lowest enabled address, and go to FETCH; if cmd_mask==0, go directly to START.
REQ-021 FETCH SHALL assert mem_rd_en for one cycle with mem_addr = latched base + k (modulo 2^MEM_AW, wrap allowed), then go to LOAD.
REQ-022 LOAD SHALL capture mem_rdata on its first cycle and hold pcpi_valid=1 with funct3=000, addr=k, value=captured data until a cycle with pcpi_ready=1 (transfer).
REQ-023 After a transfer, pcpi_valid SHALL be low for at least one cycle; k SHALL advance to the next enabled address (skipping disabled groups), returning to FETCH, or to START when none remain.
REQ-024 Per job, exactly one write per enabled address SHALL be issued, in ascending address order.
REQ-025 START SHALL hold pcpi_valid=1, funct3=111, addr=0, value=0 until pcpi_ready=1, then enter RUN with run counter = 0.
REQ-026 RUN SHALL keep pcpi_valid=0, increment the run counter each cycle, ignore inputs in its first cycle, and exit to CLEAR on the first later cycle with pcpi_ready=1 and pcpi_wait=0.
REQ-027 If the run counter reaches TIMEOUT before that exit condition, controller SHALL set err=1 and enter CLEAR.
REQ-028 CLEAR SHALL hold pcpi_valid=1, funct3=101, addr=0, value=0 until pcpi_ready=1, then enter DONE.
REQ-029 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-030 cmd_valid outside IDLE SHALL be ignored (no queueing).
REQ-031 mem_rd_en and pcpi_valid SHALL never be high in the same cycle.
REQ-032 Minimum job latency with mask 1111 and pcpi_ready held high: 28 x 3 cycles of load + START + RUN + CLEAR + DONE.

Reset
REQ-033 While rst=1, the next edge SHALL set state=IDLE, pcpi_valid=0, pcpi_insn=0, mem_rd_en=0, mem_addr=0, done=0, err=0, k=0, run counter=0.
REQ-034 rst asserted mid-job SHALL abort immediately with no further pcpi or memory strobes; cmd_ready SHALL be 1 the cycle after rst deasserts.

Verification
REQ-035 Mask 1111, base 0x10, memory word i = 0x0100+i, pcpi_ready always high -> 28 writes, addr 0..27, value 0x0100..0x011B, then 111, 101, one done pulse, err=0.
REQ-036 Mask 0100, base 0xFE -> exactly 9 writes addr 18..26 reading mem_addr 0x10..0x18 (wrapped, MEM_AW=8), then start/clear.
REQ-037 pcpi_ready low 5 cycles during the write for addr 4 -> insn held stable those 5 cycles, single transfer, no duplicate.
REQ-038 Model coprocessor: after 111, pcpi_ready=0 and pcpi_wait=1 for 8 cycles, then ready=1, wait=0 -> CLEAR issued the cycle after, err=0.
REQ-039 Coprocessor never completes in RUN, TIMEOUT=16 -> err=1 after 16 RUN cycles, 101 issued, done pulses, err stays 1 until next accept.
REQ-040 rst pulsed during LOAD of addr 12 -> pcpi_valid=0 next cycle, IDLE, cmd_ready=1; new job mask 0001 completes normally.
